// File: rtl/led_hue_engine.sv
// led_hue_engine
//   RGB LED effect engine: step-rate divider, hue sweep, breathing envelope,
//   HSV->RGB conversion and PWM for NUM_LEDS RGB LEDs.
//
//   Ports
//     clk         system clock
//     reset       synchronous, active-high
//     mode_next   1-cycle pulse, advances mode OFF->SWEEP->FIXED->BREATHE->OFF
//     dir         sweep direction: 0 hue increments, 1 hue decrements
//     brightness  global value V (0..255)
//     led_r/g/b   per-LED PWM pins, registered, polarity set by ACTIVE_LOW
//     mode        current mode (also the mode FSM state): 0 OFF, 1 SWEEP, 2 FIXED, 3 BREATHE
//     hue         base hue, 0..767
//     tick        1-cycle pulse every DIV = CLK_HZ/STEP_HZ clocks
//
//   LED k uses hue (hue + k*PHASE_STEP) mod 768.
//   Working duties are refreshed round-robin, one LED per clock, through a
//   two-stage pipeline. They are copied into the active duties only at the
//   last count of a PWM period, so every period runs with one consistent set.
module led_hue_engine #(
  parameter int NUM_LEDS   = 1,
  parameter int PHASE_STEP = 256,
  parameter int CLK_HZ     = 27000000,
  parameter int STEP_HZ    = 200,
  parameter int MODE_RESET = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode_next,
  input  logic                dir,
  input  logic [7:0]          brightness,
  output logic [NUM_LEDS-1:0] led_r,
  output logic [NUM_LEDS-1:0] led_g,
  output logic [NUM_LEDS-1:0] led_b,
  output logic [1:0]          mode,
  output logic [9:0]          hue,
  output logic                tick
);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_SWEEP   = 2'd1,
    M_FIXED   = 2'd2,
    M_BREATHE = 2'd3
  } mode_t;

  localparam int              DIV      = CLK_HZ / STEP_HZ;
  localparam int              DIVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam int              IDXW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_LEDS - 1);
  localparam logic [10:0]     PSTEP    = 11'(PHASE_STEP);
  localparam mode_t           MODE_INIT = mode_t'(MODE_RESET[1:0]);

  // (c * (v + 1)) >> 8: v = 255 passes c unchanged, v = 0 yields 0.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] v);
    logic [15:0] p;
    p = 16'(c) * (16'(v) + 16'd1);
    return 8'(p >> 8);
  endfunction

  // ---------------------------------------------------------------- mode FSM
  mode_t mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (mode_next) begin
      case (mode_q)
        M_OFF:     mode_d = M_SWEEP;
        M_SWEEP:   mode_d = M_FIXED;
        M_FIXED:   mode_d = M_BREATHE;
        M_BREATHE: mode_d = M_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_INIT;
    else       mode_q <= mode_d;
  end

  assign mode = mode_q;

  // ---------------------------------------------------------------- divider
  logic [DIVW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIVW'(1);
  end

  // ---------------------------------------------------------- hue and breath
  // The tick is evaluated against the mode before any same-cycle mode_next.
  logic [9:0] hue_q;
  logic [7:0] breath;
  logic       breath_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      hue_q       <= '0;
      breath      <= '0;
      breath_rise <= 1'b1;
    end else begin
      if (tick && mode_q == M_SWEEP) begin
        if (!dir) hue_q <= (hue_q == 10'd767) ? 10'd0 : hue_q + 10'd1;
        else      hue_q <= (hue_q == 10'd0) ? 10'd767 : hue_q - 10'd1;
      end
      if (mode_next && mode_q == M_FIXED) begin
        breath      <= '0;
        breath_rise <= 1'b1;
      end else if (tick && mode_q == M_BREATHE) begin
        if (breath_rise) begin
          // The peak is held for one tick: this tick only flips direction.
          if (breath == 8'd255) breath_rise <= 1'b0;
          else                  breath      <= breath + 8'd1;
        end else begin
          breath <= breath - 8'd1;
          if (breath == 8'd1) breath_rise <= 1'b1;
        end
      end
    end
  end

  assign hue = hue_q;

  // ---------------------------------------------------------- effective V
  logic [7:0] v_eff;

  always_comb begin
    v_eff = '0;
    case (mode_q)
      M_OFF:     v_eff = '0;
      M_SWEEP,
      M_FIXED:   v_eff = brightness;
      M_BREATHE: v_eff = scale8(breath, brightness);
    endcase
  end

  // ------------------------------------------------- channel index + phase
  // phase_off tracks idx*PHASE_STEP mod 768 incrementally, so no multiply
  // or modulo by a non-power-of-two is needed.
  logic [IDXW-1:0] idx;
  logic [9:0]      phase_off;
  logic [10:0]     phase_sum;
  logic [9:0]      phase_nxt;

  assign phase_sum = {1'b0, phase_off} + PSTEP;
  assign phase_nxt = 10'((phase_sum >= 11'd768) ? phase_sum - 11'd768 : phase_sum);

  always_ff @(posedge clk) begin
    if (reset || idx == IDX_LAST) begin
      idx       <= '0;
      phase_off <= '0;
    end else begin
      idx       <= idx + IDXW'(1);
      phase_off <= phase_nxt;
    end
  end

  // ---------------------------------------------- stage 1: hue -> raw RGB
  logic [10:0] hue_sum;
  logic [9:0]  led_hue;
  logic [7:0]  up, dn;
  logic [7:0]  raw_r, raw_g, raw_b;

  assign hue_sum = {1'b0, hue_q} + {1'b0, phase_off};
  assign led_hue = 10'((hue_sum >= 11'd768) ? hue_sum - 11'd768 : hue_sum);
  assign up      = {led_hue[6:0], 1'b0};
  assign dn      = 8'd255 - up;

  // Sector is led_hue/128, i.e. the top three bits; values 6 and 7 never occur.
  always_comb begin
    raw_r = '0;
    raw_g = '0;
    raw_b = '0;
    case (led_hue[9:7])
      3'd0: begin raw_r = 8'd255; raw_g = up;     raw_b = 8'd0;   end
      3'd1: begin raw_r = dn;     raw_g = 8'd255; raw_b = 8'd0;   end
      3'd2: begin raw_r = 8'd0;   raw_g = 8'd255; raw_b = up;     end
      3'd3: begin raw_r = 8'd0;   raw_g = dn;     raw_b = 8'd255; end
      3'd4: begin raw_r = up;     raw_g = 8'd0;   raw_b = 8'd255; end
      3'd5: begin raw_r = 8'd255; raw_g = 8'd0;   raw_b = dn;     end
      default: ;
    endcase
  end

  logic [IDXW-1:0] s1_idx;
  logic [7:0]      s1_r, s1_g, s1_b, s1_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_idx <= '0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
      s1_v   <= '0;
    end else begin
      s1_idx <= idx;
      s1_r   <= raw_r;
      s1_g   <= raw_g;
      s1_b   <= raw_b;
      s1_v   <= v_eff;
    end
  end

  // ---------------------------------------------- stage 2: scale by V
  logic [7:0] sc_r, sc_g, sc_b;

  assign sc_r = scale8(s1_r, s1_v);
  assign sc_g = scale8(s1_g, s1_v);
  assign sc_b = scale8(s1_b, s1_v);

  // ---------------------------------------------------------------- PWM
  logic [7:0] pwm_cnt;
  logic       pwm_last;

  assign pwm_last = (pwm_cnt == 8'd254);

  always_ff @(posedge clk) begin
    if (reset)         pwm_cnt <= '0;
    else if (pwm_last) pwm_cnt <= '0;
    else               pwm_cnt <= pwm_cnt + 8'd1;
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
    logic [7:0] dw_r, dw_g, dw_b;   // working duties
    logic [7:0] da_r, da_g, da_b;   // active duties for the running period
    logic       pin_r, pin_g, pin_b;

    always_ff @(posedge clk) begin
      if (reset) begin
        dw_r  <= '0;
        dw_g  <= '0;
        dw_b  <= '0;
        da_r  <= '0;
        da_g  <= '0;
        da_b  <= '0;
        pin_r <= ACTIVE_LOW;
        pin_g <= ACTIVE_LOW;
        pin_b <= ACTIVE_LOW;
      end else begin
        if (s1_idx == IDXW'(k)) begin
          dw_r <= sc_r;
          dw_g <= sc_g;
          dw_b <= sc_b;
        end
        if (pwm_last) begin
          da_r <= dw_r;
          da_g <= dw_g;
          da_b <= dw_b;
        end
        pin_r <= (pwm_cnt < da_r) ^ ACTIVE_LOW;
        pin_g <= (pwm_cnt < da_g) ^ ACTIVE_LOW;
        pin_b <= (pwm_cnt < da_b) ^ ACTIVE_LOW;
      end
    end

    assign led_r[k] = pin_r;
    assign led_g[k] = pin_g;
    assign led_b[k] = pin_b;
  end

endmodule
